// File: rtl/period_meter_pkg.sv
// Shared constants for the period measurement block: FSM encodings and state helpers.
package period_meter_pkg;

    typedef logic [1:0] pm_state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    function automatic logic pm_is_busy(input pm_state_t st);
        return (st == ST_ARM) || (st == ST_MEASURE);
    endfunction

endpackage

// File: rtl/period_meter_sync_edge.sv
// Multi-stage synchronizer for an asynchronous level followed by a rising-edge pulse.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iClk,
    input  logic iRst,
    input  logic signal_i,
    output logic edge_o
);

    // SYNC_STAGES must be at least 2; the shift below relies on it.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures the clock-cycle distance between consecutive rising edges of an async input,
// holding the result in a valid/acknowledge register with saturation/overflow reporting.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iSignal,
    input  logic             iEnable,
    input  logic             iAck,
    output logic [WIDTH-1:0] oPeriod,
    output logic             oValid,
    output logic             oOverflow,
    output logic             oBusy
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic edge_pulse;

    pm_state_t        state_q,    state_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic [WIDTH-1:0] period_q,   period_d;
    logic             valid_q,    valid_d;
    logic             overflow_q, overflow_d;
    logic             busy_q,     busy_d;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .iClk    (iClk),
        .iRst    (iRst),
        .signal_i(iSignal),
        .edge_o  (edge_pulse)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (iEnable) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!iEnable) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (edge_pulse) begin
                    state_d = ST_MEASURE;
                    count_d = {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_MEASURE: begin
                // Dropping enable aborts silently, even if an edge or saturation coincides.
                if (!iEnable) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (edge_pulse) begin
                    state_d    = ST_DONE;
                    period_d   = count_q;
                    overflow_d = 1'b0;
                    valid_d    = 1'b1;
                end else if (count_q == CNT_MAX) begin
                    state_d    = ST_DONE;
                    period_d   = CNT_MAX;
                    overflow_d = 1'b1;
                    valid_d    = 1'b1;
                end else begin
                    count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (iAck) begin
                    valid_d = 1'b0;
                    count_d = '0;
                    state_d = iEnable ? ST_ARM : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Busy is registered from the next state so it tracks the state register exactly.
    assign busy_d = pm_is_busy(state_d);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign oPeriod   = period_q;
    assign oValid    = valid_q;
    assign oOverflow = overflow_q;
    assign oBusy     = busy_q;

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period of an asynchronous digital input as a count of `iClk` cycles between two consecutive rising edges. It is the consuming end of the counter blocks: where a counter produces a count, this block recovers one from an external waveform. The result is held in a valid/acknowledge register for a downstream consumer such as a display driver or register file. The count uses a saturating counter with an overflow flag.

## Interface
Parameters:
- `WIDTH`, 16: width of the period counter and of `oPeriod`.
- `SYNC_STAGES`, 2: flip-flop stages in the input synchronizer; minimum 2.

Ports:
- `iClk`, in, 1: clock.
- `iRst`, in, 1: reset, synchronous, active-high.
- `iSignal`, in, 1: asynchronous input waveform.
- `iEnable`, in, 1: level; starts and continues measurement while high.
- `iAck`, in, 1: consumer acknowledge; clears `oValid`.
- `oPeriod`, out, `WIDTH`: measured period in `iClk` cycles.
- `oValid`, out, 1: `oPeriod` and `oOverflow` are valid.
- `oOverflow`, out, 1: no second edge arrived before the counter saturated.
- `oBusy`, out, 1: high in ARM or MEASURE.

## Operation
- **Input path:** `iSignal` passes through `SYNC_STAGES` flip-flops, then a previous-value register.
- **Edge pulse:** `edge` is a one-cycle pulse meaning synchronized value is 1 and previous value is 0.
- **FSM states:** IDLE, ARM, MEASURE, DONE.
- **IDLE:** counter held at 0. Goes to ARM when `iEnable` = 1.
- **ARM:**
  - On `edge`: counter ← 1, go to MEASURE.
  - On `iEnable` = 0: go to IDLE.
- **MEASURE:**
  - On `edge`: `oPeriod` ← counter, `oOverflow` ← 0, `oValid` ← 1, go to DONE.
  - Else, if counter = 2^`WIDTH`−1: `oPeriod` ← all ones, `oOverflow` ← 1, `oValid` ← 1, go to DONE.
  - Else: counter ← counter + 1.
  - On `iEnable` = 0: go to IDLE, no result. This takes priority over `edge` and overflow in the same cycle.
- **DONE:**
  - `oValid`, `oPeriod` and `oOverflow` are held stable.
  - `edge` and `iEnable` are ignored.
  - On `iAck` = 1: `oValid` ← 0, then go to ARM if `iEnable` = 1, else IDLE.
  - The next measurement starts only at the first `edge` seen in ARM. Edges in the acknowledge cycle are not used.
- **Acknowledge outside DONE:** `iAck` has no effect.
- **Counter arithmetic:** unsigned `WIDTH`-bit and saturating; it never wraps. An edge exactly at counter = max reports max with `oOverflow` = 0.
- **Reported period:** input edges N cycles apart give `oPeriod` = N. The minimum measurable period is 2.
- **Edges outside ARM/MEASURE:** ignored, including a spurious edge after reset when `iSignal` is already high.

## Timing
- **Reset:** all state is cleared on the next `iClk` edge, including mid-operation. State is IDLE; `oPeriod` = 0, `oValid` = 0, `oOverflow` = 0, `oBusy` = 0; counter and synchronizer are 0.
- **Edge detection latency:** a rising edge of `iSignal` sampled at clock k produces `edge` in cycle k + `SYNC_STAGES`.
- **Result latency:** `oValid` rises on the clock edge that ends the cycle in which the terminating `edge` is high. It is visible in the following cycle.
- **Enable latency:** `oBusy` follows the state register, so it rises one cycle after `iEnable` is sampled high in IDLE.
- **Acknowledge timing:**
  - `oValid` falls in the cycle after `iAck` is sampled high.
  - A single-cycle `iAck` is sufficient.
  - `iAck` held high in DONE clears `oValid` exactly once.
- **Registered outputs:** all outputs come directly from registers; no combinational path from any input.

## Structure
- FSM state encodings (2 bits: IDLE = 0, ARM = 1, MEASURE = 2, DONE = 3) go in the shared constants include file, next to the other counter blocks' constants.
- Sub-module `sync_edge_detect`, parameterized by `SYNC_STAGES`. It contains the synchronizer chain plus the rising-edge pulse and is reusable by other blocks with asynchronous inputs.
- The top level holds the FSM, the saturating counter and the output registers.

## Test plan
- **Basic measurement:** Reset, `iEnable` = 1, square wave with period 10 (5 high, 5 low). Expect `oPeriod` = 10, `oValid` = 1, `oOverflow` = 0, held until `iAck`. After `iAck`, the next result is again 10.
- **Minimum period:** period-2 waveform. Expect `oPeriod` = 2. Then a period-37 waveform with 1-cycle-high pulses; expect 37.
- **Overflow:** `WIDTH` = 4, one rising edge and no second edge. Expect `oValid` = 1, `oOverflow` = 1, `oPeriod` = 15 exactly 15 cycles after the arming edge pulse.
- **Saturation boundary:** `WIDTH` = 4, edges exactly 15 cycles apart. Expect `oPeriod` = 15, `oOverflow` = 0.
- **Abort and hold:**
  - Drop `iEnable` during MEASURE. Expect `oBusy` = 0, `oValid` never asserted, and the next measurement correct.
  - Withhold `iAck` for 50 cycles while edges continue. Expect `oPeriod` unchanged.
- **Reset during operation:** assert `iRst` for one cycle during MEASURE and again during DONE. Every output is 0 the next cycle, and the block stays IDLE until `iEnable` is sampled high again.
